// File: rtl/ofifo_collect.sv
// ofifo_collect: per-column FIFOs absorbing the skewed wavefront and releasing aligned rows; OFIFO_RELU_EN clamps negative lanes to zero on output
module ofifo_collect #(
  parameter int col = 8,
  parameter int psum_bw = 16,
  parameter int depth = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic                   o_ready,
  output logic                   o_full,
  output logic                   o_valid,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_ovf
);
  localparam int aw = $clog2(depth);
  localparam logic [aw-1:0] inc = 1;
  localparam logic [aw:0] one = 1;
  localparam logic [aw:0] dmax = (aw+1)'(depth);
  logic [col-1:0] nonempty;
  logic [col-1:0] full;
  logic [col-1:0] ovf_hit;
  logic [psum_bw*col-1:0] row;
  logic pop;
  assign o_ready = &nonempty;
  assign o_full = |full;
  assign pop = rd & o_ready;
  for (genvar c = 0; c < col; c++) begin : g_lane
    logic [psum_bw-1:0] mem [depth];
    logic [aw-1:0] wptr;
    logic [aw-1:0] rptr;
    logic [aw:0] cnt;
    logic we;
    logic [psum_bw-1:0] head;
    assign full[c] = cnt == dmax;
    assign nonempty[c] = cnt != '0;
    assign we = wr[c] & (~full[c] | pop);
    assign ovf_hit[c] = wr[c] & full[c] & ~pop;
    assign head = mem[rptr];
`ifdef OFIFO_RELU_EN
    assign row[psum_bw*c +: psum_bw] = head[psum_bw-1] ? '0 : head;
`else
    assign row[psum_bw*c +: psum_bw] = head;
`endif
    always_ff @(posedge clk)
      if (reset && we) mem[wptr] <= in[psum_bw*c +: psum_bw];
    always_ff @(posedge clk)
      if (!reset) begin
        wptr <= '0;
        rptr <= '0;
        cnt <= '0;
      end else begin
        wptr <= we ? wptr + inc : wptr;
        rptr <= pop ? rptr + inc : rptr;
        cnt <= (we && !pop) ? cnt + one : (pop && !we) ? cnt - one : cnt;
      end
  end
  always_ff @(posedge clk)
    if (!reset) begin
      o_valid <= 1'b0;
      out <= '0;
      o_ovf <= 1'b0;
    end else begin
      o_valid <= pop;
      out <= pop ? row : out;
      o_ovf <= o_ovf | (|ovf_hit);
    end
endmodule
